// File: rtl/exp_golomb_decoder_pkg.sv
// Shared types and helpers for the order-0 Exp-Golomb decoder.
// The log2 here is the same helper the bit buffer uses for its port widths.
package exp_golomb_decoder_pkg;

  typedef enum logic [1:0] {
    StPrefix,
    StSuffix,
    StOut,
    StError
  } state_e;

  // Suffix length is prefix length plus the code order.
  localparam int unsigned EgOrder = 0;

  // Ceiling log2, never less than 1 so it is safe as a port width.
  function automatic int unsigned log2(input int unsigned x);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < x) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Finds the lowest set bit among the first `avail` bits of a vector.
module lsb_priority_encoder
  import exp_golomb_decoder_pkg::*;
#(
  parameter int unsigned WIDTH = 7,
  localparam int unsigned CntW = log2(WIDTH + 1),
  localparam int unsigned IdxW = log2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [CntW-1:0]  avail,
  output logic             found,
  output logic [IdxW-1:0]  idx
);

  // Scan from the top so the lowest qualifying bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (vec[i] && (i < int'(avail))) begin
        found = 1'b1;
        idx   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/exp_golomb_decoder.sv
// Order-0 Exp-Golomb decoder sitting on a variable-length bit buffer window.
// Drives the buffer's pop combinationally and presents values on valid/ready.
module exp_golomb_decoder
  import exp_golomb_decoder_pkg::*;
#(
  parameter int unsigned WIDTH_OUT    = 8,
  parameter int unsigned BUFFER_WIDTH = 16,
  parameter int unsigned MAX_PREFIX   = 15,
  parameter int unsigned VALUE_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH_OUT-1:0]              q,
  input  logic [log2(BUFFER_WIDTH)-1:0]     size,
  output logic [log2(WIDTH_OUT)-1:0]        pop,
  output logic [VALUE_WIDTH-1:0]            value,
  output logic                              valid,
  input  logic                              ready,
  output logic                              error
);

  localparam int unsigned Win  = WIDTH_OUT - 1;
  localparam int unsigned PopW = log2(WIDTH_OUT);
  localparam int unsigned KW   = log2(MAX_PREFIX + WIDTH_OUT);
  localparam int unsigned AccW = MAX_PREFIX + 1;
  localparam int unsigned IdxW = log2(Win);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d, rem_q, rem_d, k_sum;
  logic [AccW-1:0]   acc_q, acc_d, shifted;
  logic              valid_q, valid_d, error_q, error_d;
  logic [PopW-1:0]   avail, n, pop_c;
  logic              found;
  logic [IdxW-1:0]   idx;
  logic              unused_q_msb;

  // The top window bit is never consumed: at most Win bits pop per cycle.
  assign unused_q_msb = q[WIDTH_OUT-1];

  always_comb begin
    if (int'(size) >= int'(Win)) avail = PopW'(Win);
    else                         avail = PopW'(size);
  end

  lsb_priority_encoder #(
    .WIDTH (Win)
  ) u_lsb_enc (
    .vec   (q[Win-1:0]),
    .avail (avail),
    .found (found),
    .idx   (idx)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    error_d = error_q;
    pop_c   = '0;
    k_sum   = k_q;
    n       = '0;
    shifted = acc_q;
    unique case (state_q)
      StPrefix: begin
        if (avail != '0) begin
          if (found) begin
            pop_c = PopW'(idx) + PopW'(1);
            k_sum = k_q + KW'(idx);
            acc_d = AccW'(1);
          end else begin
            pop_c = avail;
            k_sum = k_q + KW'(avail);
          end
          k_d = k_sum;
          if (k_sum > KW'(MAX_PREFIX)) begin
            state_d = StError;
            error_d = 1'b1;
          end else if (found) begin
            rem_d = k_sum + KW'(EgOrder);
            if (rem_d == '0) begin
              state_d = StOut;
              valid_d = 1'b1;
            end else begin
              state_d = StSuffix;
            end
          end
        end
      end
      StSuffix: begin
        if (avail != '0) begin
          if (rem_q < KW'(avail)) n = PopW'(rem_q);
          else                    n = avail;
          // q[0] is the oldest bit, so it lands in the most significant position.
          for (int j = 0; j < int'(Win); j++) begin
            if (j < int'(n)) shifted = {shifted[AccW-2:0], q[j]};
          end
          acc_d = shifted;
          pop_c = n;
          rem_d = rem_q - KW'(n);
          if (rem_d == '0) begin
            state_d = StOut;
            valid_d = 1'b1;
          end
        end
      end
      StOut: begin
        if (ready) begin
          state_d = StPrefix;
          k_d     = '0;
          acc_d   = '0;
          valid_d = 1'b0;
        end
      end
      StError: begin
        state_d = StError;
      end
      default: state_d = StPrefix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StPrefix;
      k_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign pop   = rst ? pop_c : '0;
  assign value = VALUE_WIDTH'(acc_q - AccW'(1));
  assign valid = valid_q;
  assign error = error_q;

endmodule

// File: tb/tb_exp_golomb_decoder.sv
// Bench for exp_golomb_decoder: a queue-based bit-buffer model feeds the DUT,
// values are encoded arithmetically and compared against a scoreboard.
module tb_exp_golomb_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  q;
  logic [3:0]  size;
  logic [2:0]  pop;
  logic [15:0] value;
  logic        valid;
  logic        ready;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;

  bit          bits[$];
  int unsigned expq[$];

  int          s_pop;
  int          s_size;
  logic        s_valid;
  logic        s_error;
  logic [15:0] s_value;

  always #5 clk = ~clk;

  exp_golomb_decoder #(
    .WIDTH_OUT    (8),
    .BUFFER_WIDTH (16),
    .MAX_PREFIX   (15),
    .VALUE_WIDTH  (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .q     (q),
    .size  (size),
    .pop   (pop),
    .value (value),
    .valid (valid),
    .ready (ready),
    .error (error)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Append the codeword for v: k zeros, then v+1 written MSB first in k+1 bits.
  task automatic push_value(input int unsigned v);
    int unsigned x;
    int          k;
    x = v + 1;
    k = 0;
    while ((x >> (k + 1)) != 0) k++;
    repeat (k) bits.push_back(1'b0);
    for (int b = k; b >= 0; b--) bits.push_back(x[b]);
  endtask

  // One cycle of the buffer model: expose up to lim bits, junk beyond them.
  task automatic step(input int lim, input logic rdy);
    int         sz;
    logic [7:0] w;
    @(negedge clk);
    sz = bits.size();
    if (sz > lim) sz = lim;
    if (sz > 15) sz = 15;
    for (int j = 0; j < 8; j++) w[j] = (j < sz) ? bits[j] : 1'($urandom);
    q     = w;
    size  = 4'(sz);
    ready = rdy;
    #1;
    s_size  = sz;
    s_pop   = int'(pop);
    s_valid = valid;
    s_value = value;
    s_error = error;
    @(posedge clk);
    for (int j = 0; j < s_pop; j++) if (bits.size() > 0) void'(bits.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int unsigned kk, v;

    rst   = 1'b0;
    q     = 8'hFF;
    size  = 4'd5;
    ready = 1'b0;
    #3;
    check_eq("reset_pop", pop, 0);
    check_eq("reset_valid", valid, 0);
    check_eq("reset_error", error, 0);
    @(negedge clk);
    size = 4'd0;
    rst  = 1'b1;

    // Codeword "1" with extra bits behind it.
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    step(15, 1'b1);
    check_eq("one_pop", s_pop, 1);
    check_eq("one_valid_early", s_valid, 0);
    step(0, 1'b1);
    check_eq("one_valid", s_valid, 1);
    check_eq("one_value", s_value, 0);
    bits.delete();

    // Stream 0,1,1 decodes to 2.
    bits = '{1'b0, 1'b1, 1'b1};
    step(15, 1'b1);
    check_eq("b_pop0", s_pop, 2);
    step(15, 1'b1);
    check_eq("b_pop1", s_pop, 1);
    step(15, 1'b1);
    check_eq("b_value", s_value, 2);
    check_eq("b_valid", s_valid, 1);
    bits.delete();

    // Nine zeros, a one, info 9'h1FF, window of 8 bits.
    push_value(1022);
    step(8, 1'b1);
    check_eq("c_pop0", s_pop, 7);
    step(8, 1'b1);
    check_eq("c_pop1", s_pop, 3);
    step(8, 1'b1);
    check_eq("c_pop2", s_pop, 7);
    step(8, 1'b1);
    check_eq("c_pop3", s_pop, 2);
    step(8, 1'b1);
    check_eq("c_value", s_value, 1022);
    bits.delete();

    // Suffix starvation, then a three-cycle ready stall.
    push_value(53);
    step(6, 1'b1);
    check_eq("d_prefix_pop", s_pop, 6);
    step(3, 1'b1);
    check_eq("d_pop3", s_pop, 3);
    step(0, 1'b1);
    check_eq("d_starve_pop", s_pop, 0);
    step(0, 1'b1);
    check_eq("d_starve_pop2", s_pop, 0);
    check_eq("d_starve_valid", s_valid, 0);
    step(2, 1'b1);
    check_eq("d_pop2", s_pop, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0);
      check_eq("e_hold_valid", s_valid, 1);
      check_eq("e_hold_value", s_value, 53);
      check_eq("e_hold_pop", s_pop, 0);
    end
    push_value(0);
    step(15, 1'b1);
    check_eq("e_accept_value", s_value, 53);
    check_eq("e_accept_pop", s_pop, 0);
    step(15, 1'b1);
    check_eq("e_next_pop", s_pop, 1);
    step(15, 1'b1);
    check_eq("e_next_value", s_value, 0);
    check_eq("e_next_valid", s_valid, 1);
    bits.delete();

    // Prefix overflow: 24 zeros with an 8-bit window.
    repeat (24) bits.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8, 1'b1);
      check_eq("f_pop", s_pop, 7);
      check_eq("f_error_low", s_error, 0);
    end
    step(8, 1'b1);
    check_eq("f_error", s_error, 1);
    check_eq("f_err_pop", s_pop, 0);
    check_eq("f_err_valid", s_valid, 0);
    step(8, 1'b1);
    check_eq("f_err_pop2", s_pop, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("f_async_clear", error, 0);
    check_eq("f_rst_pop", pop, 0);
    @(negedge clk);
    size = 4'd0;
    rst  = 1'b1;
    bits.delete();
    push_value(5);
    step(15, 1'b1);
    check_eq("f_resume_pop0", s_pop, 3);
    step(15, 1'b1);
    check_eq("f_resume_pop1", s_pop, 2);
    step(15, 1'b1);
    check_eq("f_resume_value", s_value, 5);
    bits.delete();

    // Random codewords under random window sizes and backpressure.
    for (int i = 0; i < 200; i++) begin
      kk = $urandom_range(15, 0);
      v  = (32'd1 << kk) - 1 + ($urandom & ((32'd1 << kk) - 1));
      expq.push_back(v);
      push_value(v);
    end
    cyc = 0;
    while (expq.size() > 0 && cyc < 20000) begin
      logic rdy;
      rdy = ($urandom_range(9, 0) < 7);
      step($urandom_range(15, 0), rdy);
      cyc++;
      if (s_pop > s_size) check_eq("rand_pop_bound", s_pop, s_size);
      if (s_valid && rdy) begin
        check_eq("rand_value", s_value, expq.pop_front());
      end
    end
    check_eq("rand_drain", expq.size(), 0);
    check_eq("rand_bits_left", bits.size(), 0);
    check_eq("rand_no_error", error, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
